// File: rtl/bram_sdp_pkg.sv
// Shared constants, clear-FSM state type and sizing helpers for the bram_sdp block.
package bram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int num_bytes(input int width, input int byte_w);
        return width / byte_w;
    endfunction

endpackage

// File: rtl/bram_sdp_if.sv
// Write port, read port and clear-control bundle of bram_sdp; master drives, slave is the RAM.
interface bram_sdp_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int BYTE_W = 8
) ();
    localparam int NBYTES = bram_pkg::num_bytes(WIDTH, BYTE_W);
    localparam int AW     = bram_pkg::addr_width(DEPTH);

    logic              wen;
    logic [NBYTES-1:0] wbe;
    logic [AW-1:0]     waddr;
    logic [WIDTH-1:0]  wdata;
    logic              ren;
    logic [AW-1:0]     raddr;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;
    logic              clr;
    logic              busy;

    modport master (
        output wen, wbe, waddr, wdata, ren, raddr, clr,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  wen, wbe, waddr, wdata, ren, raddr, clr,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/bram_sdp_clear_ctrl.sv
// Clear sequencer: sweeps every address once, owning the write port while busy.
module bram_clear_ctrl
    import bram_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter int CLEAR_ON_RESET = 1,
    parameter int AW             = 10
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          clr,
    output logic          busy,
    output logic          cwen,
    output logic [AW-1:0] caddr
);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    // Resetting straight into CLEAR makes the first edge after reset write address 0.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cwen      = 1'b0;
        case (state)
            IDLE: begin
                if (clr) state_nxt = CLEAR;
            end
            CLEAR: begin
                cwen = 1'b1;
                if (cnt == AW'(DEPTH - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

    assign busy  = (state == CLEAR);
    assign caddr = cnt;

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write and 1/2-cycle read latency.
module bram_sdp
    import bram_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               DEPTH          = 1024,
    parameter int               BYTE_W         = 8,
    parameter int               RD_LATENCY     = 1,
    parameter int               RDW_MODE       = RDW_READ_FIRST,
    parameter int               CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] INIT_VAL       = '0
) (
    input logic       clk,
    input logic       areset,
    bram_sdp_if.slave bus
);

    localparam int NBYTES = num_bytes(WIDTH, BYTE_W);
    localparam int AW     = addr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic          busy;
    logic          cwen;
    logic [AW-1:0] caddr;

    bram_clear_ctrl #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .AW             (AW)
    ) u_clear_ctrl (
        .clk    (clk),
        .areset (areset),
        .clr    (bus.clr),
        .busy   (busy),
        .cwen   (cwen),
        .caddr  (caddr)
    );

    assign bus.busy = busy;

    logic              wr_go;
    logic [AW-1:0]     wr_addr;
    logic [NBYTES-1:0] wr_be;
    logic [WIDTH-1:0]  wr_word;

    // The sweep takes the write port outright; user writes only land when idle and in range.
    always_comb begin
        wr_go   = 1'b0;
        wr_addr = bus.waddr;
        wr_be   = bus.wbe;
        wr_word = bus.wdata;
        if (cwen) begin
            wr_go   = 1'b1;
            wr_addr = caddr;
            wr_be   = '1;
            wr_word = INIT_VAL;
        end else if (bus.wen && !busy && (int'(bus.waddr) < DEPTH)) begin
            wr_go = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_word[i*BYTE_W +: BYTE_W];
            end
        end
    end

    logic             rd_go;
    logic [WIDTH-1:0] rd_word;

    assign rd_go = bus.ren && !busy;

    // Write-first merges only the lanes being written this cycle over the stored word.
    always_comb begin
        rd_word = '0;
        if (int'(bus.raddr) < DEPTH) begin
            rd_word = mem[bus.raddr];
            if ((RDW_MODE == RDW_WRITE_FIRST) && wr_go && !cwen && (wr_addr == bus.raddr)) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (wr_be[i]) rd_word[i*BYTE_W +: BYTE_W] = wr_word[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    logic             v1;
    logic [WIDTH-1:0] d1;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= rd_go;
            if (rd_go) d1 <= rd_word;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic             v2;
        logic [WIDTH-1:0] d2;

        always_ff @(posedge clk or posedge areset) begin
            if (areset) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                if (v1) d2 <= d1;
            end
        end

        assign bus.rvalid = v2;
        assign bus.rdata  = d2;
    end else begin : g_lat1
        assign bus.rvalid = v1;
        assign bus.rdata  = d1;
    end

endmodule

// File: tb/tb_bram_sdp.sv
// Drives two bram_sdp configurations with identical stimulus and checks both against a behavioural model.
module tb_bram_sdp;
    import bram_pkg::*;

    localparam int          DEP_A  = 16;
    localparam int          DEP_B  = 12;
    localparam logic [31:0] INIT_A = 32'h0000_0000;
    localparam logic [31:0] INIT_B = 32'hA5A5_5A5A;

    logic clk    = 1'b0;
    logic areset = 1'b0;
    always #5 clk = ~clk;

    bram_sdp_if #(.WIDTH(32), .DEPTH(DEP_A), .BYTE_W(8)) bus_a ();
    bram_sdp_if #(.WIDTH(32), .DEPTH(DEP_B), .BYTE_W(8)) bus_b ();

    assign bus_b.wen   = bus_a.wen;
    assign bus_b.wbe   = bus_a.wbe;
    assign bus_b.waddr = bus_a.waddr;
    assign bus_b.wdata = bus_a.wdata;
    assign bus_b.ren   = bus_a.ren;
    assign bus_b.raddr = bus_a.raddr;
    assign bus_b.clr   = bus_a.clr;

    bram_sdp #(
        .WIDTH(32), .DEPTH(DEP_A), .BYTE_W(8), .RD_LATENCY(1),
        .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RESET(1), .INIT_VAL(INIT_A)
    ) dut_a (.clk(clk), .areset(areset), .bus(bus_a));

    bram_sdp #(
        .WIDTH(32), .DEPTH(DEP_B), .BYTE_W(8), .RD_LATENCY(2),
        .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RESET(1), .INIT_VAL(INIT_B)
    ) dut_b (.clk(clk), .areset(areset), .bus(bus_b));

    int          m_dep  [2] = '{DEP_A, DEP_B};
    int          m_lat  [2] = '{1, 2};
    int          m_rdw  [2] = '{0, 1};
    logic [31:0] m_init [2] = '{INIT_A, INIT_B};

    logic [31:0] m_mem [2][16];
    int          m_clear_left [2];
    logic [31:0] m_rdata [2];
    logic        m_rvalid [2];

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] val;
    } rd_t;
    rd_t pend[$];

    int edge_n;
    int n_assert;
    int n_fail;

    function automatic void model_reset();
        pend.delete();
        for (int k = 0; k < 2; k++) begin
            m_clear_left[k] = m_dep[k];
            m_rdata[k]      = '0;
            m_rvalid[k]     = 1'b0;
        end
    endfunction

    // Reference model: one step per rising edge, straight from the read/write/clear rules.
    always @(posedge clk) begin
        logic [31:0] rv;
        logic        rd;
        if (!areset) begin
            edge_n++;
            for (int k = 0; k < 2; k++) begin
                rd = 1'b0;
                rv = '0;
                if (m_clear_left[k] == 0) begin
                    if (bus_a.ren) begin
                        rd = 1'b1;
                        if (int'(bus_a.raddr) < m_dep[k]) begin
                            rv = m_mem[k][bus_a.raddr];
                            if (m_rdw[k] == 1 && bus_a.wen && bus_a.waddr == bus_a.raddr)
                                for (int i = 0; i < 4; i++)
                                    if (bus_a.wbe[i]) rv[i*8 +: 8] = bus_a.wdata[i*8 +: 8];
                        end
                    end
                    if (bus_a.wen && int'(bus_a.waddr) < m_dep[k])
                        for (int i = 0; i < 4; i++)
                            if (bus_a.wbe[i]) m_mem[k][bus_a.waddr][i*8 +: 8] = bus_a.wdata[i*8 +: 8];
                    if (bus_a.clr) m_clear_left[k] = m_dep[k];
                end else begin
                    m_mem[k][m_dep[k] - m_clear_left[k]] = m_init[k];
                    m_clear_left[k]--;
                end
                if (rd) pend.push_back('{k, edge_n + m_lat[k] - 1, rv});
                m_rvalid[k] = 1'b0;
                for (int j = 0; j < pend.size(); j++) begin
                    if (pend[j].inst == k && pend[j].due == edge_n) begin
                        m_rvalid[k] = 1'b1;
                        m_rdata[k]  = pend[j].val;
                        pend.delete(j);
                        break;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_output(input string tag);
        chk({tag, " a.rvalid"}, 32'(bus_a.rvalid), 32'(m_rvalid[0]));
        chk({tag, " a.rdata"},  bus_a.rdata,       m_rdata[0]);
        chk({tag, " a.busy"},   32'(bus_a.busy),   32'(m_clear_left[0] > 0));
        chk({tag, " b.rvalid"}, 32'(bus_b.rvalid), 32'(m_rvalid[1]));
        chk({tag, " b.rdata"},  bus_b.rdata,       m_rdata[1]);
        chk({tag, " b.busy"},   32'(bus_b.busy),   32'(m_clear_left[1] > 0));
    endtask

    task automatic apply_stimulus(input logic wen, input logic [3:0] wbe, input logic [3:0] waddr,
                                  input logic [31:0] wdata, input logic ren, input logic [3:0] raddr,
                                  input logic clr, input string tag);
        bus_a.wen   = wen;
        bus_a.wbe   = wbe;
        bus_a.waddr = waddr;
        bus_a.wdata = wdata;
        bus_a.ren   = ren;
        bus_a.raddr = raddr;
        bus_a.clr   = clr;
        @(negedge clk);
        check_output(tag);
    endtask

    task automatic run_idle(input int n, input string tag);
        for (int c = 0; c < n; c++) apply_stimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, tag);
    endtask

    task automatic read_all(input string tag);
        for (int a = 0; a < 16; a++) apply_stimulus(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a), 1'b0, tag);
        run_idle(3, tag);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        edge_n   = 0;
        bus_a.wen = 1'b0; bus_a.wbe = '0; bus_a.waddr = '0; bus_a.wdata = '0;
        bus_a.ren = 1'b0; bus_a.raddr = '0; bus_a.clr = 1'b0;

        #1 areset = 1'b1;
        model_reset();
        #1 check_output("reset");
        chk("reset busy_a", 32'(bus_a.busy), 32'd1);
        @(negedge clk);
        check_output("reset_hold");
        areset = 1'b0;

        run_idle(15, "por_sweep");
        chk("por busy_a last", 32'(bus_a.busy), 32'd1);
        run_idle(1, "por_sweep_end");
        chk("por busy_a done", 32'(bus_a.busy), 32'd0);
        run_idle(2, "por_idle");
        read_all("por_readback");

        apply_stimulus(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, "wr_full");
        apply_stimulus(1'b1, 4'h2, 4'd5, 32'h0000AA00, 1'b0, 4'd0, 1'b0, "wr_lane1");
        apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0, "rd_merge");
        chk("merge a", bus_a.rdata, 32'hDEADAAEF);
        run_idle(1, "rd_merge_b");
        chk("merge b", bus_b.rdata, 32'hDEADAAEF);

        apply_stimulus(1'b1, 4'hF, 4'd3, 32'h11111111, 1'b0, 4'd0, 1'b0, "rdw_old");
        apply_stimulus(1'b1, 4'hF, 4'd3, 32'h22222222, 1'b1, 4'd3, 1'b0, "rdw_same");
        chk("rdw read_first a", bus_a.rdata, 32'h11111111);
        run_idle(1, "rdw_b");
        chk("rdw write_first b", bus_b.rdata, 32'h22222222);
        chk("rdw valid b", 32'(bus_b.rvalid), 32'd1);

        for (int a = 0; a < 3; a++)
            apply_stimulus(1'b1, 4'hF, 4'(a), 32'h100 + 32'(a), 1'b0, 4'd0, 1'b0, "lat_fill");
        apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0, 1'b0, "lat_rd0");
        chk("lat2 early b", 32'(bus_b.rvalid), 32'd0);
        apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1, 1'b0, "lat_rd1");
        chk("lat2 first b", bus_b.rdata, 32'h100);
        apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2, 1'b0, "lat_rd2");
        chk("lat2 second b", bus_b.rdata, 32'h101);
        run_idle(1, "lat_drain");
        chk("lat2 third b", bus_b.rdata, 32'h102);
        run_idle(1, "lat_drain2");
        chk("lat2 done b", 32'(bus_b.rvalid), 32'd0);

        for (int c = 0; c < 300; c++)
            apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), $urandom,
                           1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 49) == 0), "random");
        run_idle(20, "random_drain");

        apply_stimulus(1'b1, 4'hF, 4'd6, $urandom, 1'b1, 4'd4, 1'b1, "clr_start");
        for (int c = 0; c < 20; c++)
            apply_stimulus(1'b1, 4'($urandom), 4'($urandom), $urandom, 1'b1, 4'($urandom),
                           (c == 5), "clr_busy");
        chk("clr done a", 32'(bus_a.busy), 32'd0);
        run_idle(2, "clr_idle");
        read_all("clr_readback");

        apply_stimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1, 1'b1, "mid_clr");
        for (int c = 0; c < 40 && m_clear_left[0] != DEP_A - 7; c++) run_idle(1, "mid_sweep");
        chk("mid_sweep busy_a", 32'(bus_a.busy), 32'd1);
        areset = 1'b1;
        model_reset();
        #1 check_output("mid_reset");
        chk("mid_reset rdata_a", bus_a.rdata, 32'h0);
        @(negedge clk);
        areset = 1'b0;
        run_idle(16, "restart_sweep");
        chk("restart done a", 32'(bus_a.busy), 32'd0);
        run_idle(2, "restart_idle");
        read_all("restart_readback");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
